// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master RAM bus arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        BUSY    = ST_BUSY,
        RELEASE = ST_RELEASE
    } state_t;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

    // One-hot grant vector for a single-bit owner index.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating BUSY-cycle counter; expire_c flags the last permitted wait cycle.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    // A zero TIMEOUT disables the watchdog entirely.
    assign expire_c = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the CPU (master 0) and a secondary master
// shared access to one RAM port, with a timeout watchdog and sticky error.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0Addr,
    input  logic [DATA_W-1:0] m0Write,
    input  logic              m0RE,
    input  logic              m0WE,
    output logic [DATA_W-1:0] m0Read,
    output logic              m0Ready,
    input  logic [ADDR_W-1:0] m1Addr,
    input  logic [DATA_W-1:0] m1Write,
    input  logic              m1RE,
    input  logic              m1WE,
    output logic [DATA_W-1:0] m1Read,
    output logic              m1Ready,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrite,
    output logic              memRE,
    output logic              memWE,
    input  logic [DATA_W-1:0] memRead,
    input  logic              memReady,
    output logic [1:0]        grant,
    output logic              timeoutErr,
    input  logic              clearErr
);

    state_t state;
    logic   owner;
    logic   last_grant;

    logic req0, req1;
    logic owner_re, owner_we, owner_req;
    logic busy, done, tmo_hit, expire_c;
    logic rdy;
    logic [DATA_W-1:0] rdata;

    assign req0      = m0RE | m0WE;
    assign req1      = m1RE | m1WE;
    assign owner_re  = owner ? m1RE : m0RE;
    assign owner_we  = owner ? m1WE : m0WE;
    assign owner_req = owner_re | owner_we;
    assign busy      = (state == BUSY);
    assign done      = busy & memReady;
    // Completion wins over timeout; a dropped request aborts silently.
    assign tmo_hit   = busy & ~memReady & owner_req & expire_c;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (~busy),
        .en       (busy),
        .expire_c (expire_c)
    );

    // Arbitration state, round-robin history and sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            timeoutErr <= 1'b0;
        end else begin
            if (tmo_hit) begin
                timeoutErr <= 1'b1;
            end else if (clearErr) begin
                timeoutErr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state <= BUSY;
                        owner <= (req0 & req1) ? ~last_grant : req1;
                    end
                end
                BUSY: begin
                    if (done | tmo_hit) begin
                        state      <= RELEASE;
                        last_grant <= owner;
                    end else if (!owner_req) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus muxing is driven only while BUSY so reset drops strobes at once.
    always_comb begin
        memAddr  = '0;
        memWrite = '0;
        memRE    = 1'b0;
        memWE    = 1'b0;
        grant    = 2'b00;
        m0Ready  = 1'b0;
        m1Ready  = 1'b0;
        m0Read   = '0;
        m1Read   = '0;
        rdy      = done | tmo_hit;
        rdata    = done ? memRead : (tmo_hit ? ERR_DATA : '0);
        if (busy) begin
            memAddr  = owner ? m1Addr  : m0Addr;
            memWrite = owner ? m1Write : m0Write;
            memRE    = owner_re;
            memWE    = owner_we & ~owner_re;
            grant    = owner_onehot(owner);
            if (owner) begin
                m1Ready = rdy;
                m1Read  = rdata;
            end else begin
                m0Ready = rdy;
                m0Read  = rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle watchdog.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0Addr, m1Addr, memAddr;
    logic [15:0] m0Write, m1Write, memWrite;
    logic        m0RE, m0WE, m1RE, m1WE;
    logic [15:0] m0Read, m1Read, memRead;
    logic        m0Ready, m1Ready;
    logic        memRE, memWE, memReady;
    logic [1:0]  grant;
    logic        timeoutErr, clearErr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (16),
        .TIMEOUT  (4),
        .ERR_DATA (16'hDEAD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0Addr     (m0Addr),
        .m0Write    (m0Write),
        .m0RE       (m0RE),
        .m0WE       (m0WE),
        .m0Read     (m0Read),
        .m0Ready    (m0Ready),
        .m1Addr     (m1Addr),
        .m1Write    (m1Write),
        .m1RE       (m1RE),
        .m1WE       (m1WE),
        .m1Read     (m1Read),
        .m1Ready    (m1Ready),
        .memAddr    (memAddr),
        .memWrite   (memWrite),
        .memRE      (memRE),
        .memWE      (memWE),
        .memRead    (memRead),
        .memReady   (memReady),
        .grant      (grant),
        .timeoutErr (timeoutErr),
        .clearErr   (clearErr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0Addr = '0; m0Write = '0; m0RE = 1'b0; m0WE = 1'b0;
        m1Addr = '0; m1Write = '0; m1RE = 1'b0; m1WE = 1'b0;
        memRead = '0; memReady = 1'b0; clearErr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        #12;
        checks++;
        if ({memRE, memWE, m0Ready, m1Ready, timeoutErr} !== 5'b0) begin
            $display("FAIL reset_strobes: got %b required 00000", {memRE, memWE, m0Ready, m1Ready, timeoutErr});
            errors++;
        end
        checks++;
        if (grant !== 2'b00) begin
            $display("FAIL reset_grant: got %b required 00", grant);
            errors++;
        end
        checks++;
        if ({m0Read, m1Read} !== 32'h0) begin
            $display("FAIL reset_read: got %h required 0", {m0Read, m1Read});
            errors++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        m0Addr = 32'h0000_1234;
        m0RE   = 1'b1;
        tick();
        checks++;
        if ({memRE, memWE, grant} !== 4'b1001) begin
            $display("FAIL read_grant: got %b required 1001", {memRE, memWE, grant});
            errors++;
        end
        checks++;
        if (memAddr !== 32'h0000_1234) begin
            $display("FAIL read_addr: got %h required 00001234", memAddr);
            errors++;
        end
        tick();
        checks++;
        if ({memRE, m0Ready} !== 2'b10) begin
            $display("FAIL read_wait: got %b required 10", {memRE, m0Ready});
            errors++;
        end
        tick();
        memReady = 1'b1;
        memRead  = 16'hBEEF;
        #1;
        checks++;
        if ({m0Ready, m1Ready} !== 2'b10 || m0Read !== 16'hBEEF || m1Read !== 16'h0) begin
            $display("FAIL read_done: got rdy %b m0Read %h m1Read %h required 10 BEEF 0000", {m0Ready, m1Ready}, m0Read, m1Read);
            errors++;
        end
        tick();
        memReady = 1'b0;
        m0RE     = 1'b0;
        #1;
        checks++;
        if ({grant, memRE, m0Ready} !== 4'b0000) begin
            $display("FAIL read_release: got %b required 0000", {grant, memRE, m0Ready});
            errors++;
        end
        tick();
        checks++;
        if (grant !== 2'b00) begin
            $display("FAIL read_idle: got %b required 00", grant);
            errors++;
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp_g;
        rst = 1'b1;
        m0WE = 1'b1; m0Write = 16'hA5A5; m0Addr = 32'h100;
        m1RE = 1'b1; m1Addr = 32'h200;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if (grant !== exp_g) begin
                $display("FAIL contend_grant[%0d]: got %b required %b", i, grant, exp_g);
                errors++;
            end
            checks++;
            if (exp_g == 2'b01) begin
                if ({memRE, memWE} !== 2'b01 || memWrite !== 16'hA5A5 || memAddr !== 32'h100) begin
                    $display("FAIL contend_m0bus[%0d]: got re/we %b data %h addr %h required 01 A5A5 100", i, {memRE, memWE}, memWrite, memAddr);
                    errors++;
                end
            end else begin
                if ({memRE, memWE} !== 2'b10 || memAddr !== 32'h200) begin
                    $display("FAIL contend_m1bus[%0d]: got re/we %b addr %h required 10 200", i, {memRE, memWE}, memAddr);
                    errors++;
                end
            end
            tick();
            memReady = 1'b1;
            memRead  = 16'h1000 + 16'(i);
            #1;
            checks++;
            if ({m1Ready, m0Ready} !== exp_g) begin
                $display("FAIL contend_ready[%0d]: got %b required %b", i, {m1Ready, m0Ready}, exp_g);
                errors++;
            end
            if (exp_g == 2'b10) begin
                checks++;
                if (m1Read !== 16'h1000 + 16'(i)) begin
                    $display("FAIL contend_m1read[%0d]: got %h required %h", i, m1Read, 16'h1000 + 16'(i));
                    errors++;
                end
            end
            tick();
            memReady = 1'b0;
            #1;
            checks++;
            if ({grant, memRE, memWE} !== 4'b0000) begin
                $display("FAIL contend_release[%0d]: got %b required 0000", i, {grant, memRE, memWE});
                errors++;
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_re_we;
        m1RE = 1'b1; m1WE = 1'b1; m1Addr = 32'h300;
        tick();
        checks++;
        if ({memRE, memWE, grant} !== 4'b1010) begin
            $display("FAIL rewe_first: got %b required 1010", {memRE, memWE, grant});
            errors++;
        end
        tick();
        checks++;
        if ({memRE, memWE} !== 2'b10) begin
            $display("FAIL rewe_second: got %b required 10", {memRE, memWE});
            errors++;
        end
        tick();
        memReady = 1'b1;
        memRead  = 16'h5A5A;
        #1;
        checks++;
        if ({memWE, m1Ready} !== 2'b01 || m1Read !== 16'h5A5A) begin
            $display("FAIL rewe_done: got we/rdy %b read %h required 01 5A5A", {memWE, m1Ready}, m1Read);
            errors++;
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        m0RE = 1'b1; m0Addr = 32'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({m0Ready, timeoutErr} !== 2'b00) begin
                $display("FAIL tmo_wait[%0d]: got %b required 00", i, {m0Ready, timeoutErr});
                errors++;
            end
        end
        tick();
        checks++;
        if ({m0Ready, grant} !== 3'b101 || m0Read !== 16'hDEAD) begin
            $display("FAIL tmo_pulse: got rdy/grant %b read %h required 101 DEAD", {m0Ready, grant}, m0Read);
            errors++;
        end
        tick();
        m0RE = 1'b0;
        #1;
        checks++;
        if ({timeoutErr, m0Ready, grant} !== 4'b1000) begin
            $display("FAIL tmo_set: got %b required 1000", {timeoutErr, m0Ready, grant});
            errors++;
        end
        tick();
        checks++;
        if (timeoutErr !== 1'b1) begin
            $display("FAIL tmo_sticky: got %b required 1", timeoutErr);
            errors++;
        end
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
        checks++;
        if (timeoutErr !== 1'b0) begin
            $display("FAIL tmo_clear: got %b required 0", timeoutErr);
            errors++;
        end
        m0RE = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        clearErr = 1'b1;
        #1;
        checks++;
        if (m0Ready !== 1'b1) begin
            $display("FAIL tmo_pulse2: got %b required 1", m0Ready);
            errors++;
        end
        tick();
        clearErr = 1'b0;
        m0RE     = 1'b0;
        checks++;
        if (timeoutErr !== 1'b1) begin
            $display("FAIL tmo_set_over_clear: got %b required 1", timeoutErr);
            errors++;
        end
        tick();
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
    endtask

    task automatic test_abort;
        m1RE = 1'b1; m1Addr = 32'h500;
        tick();
        checks++;
        if (grant !== 2'b10) begin
            $display("FAIL abort_grant: got %b required 10", grant);
            errors++;
        end
        tick();
        m1RE = 1'b0;
        #1;
        checks++;
        if ({m1Ready, memRE} !== 2'b00) begin
            $display("FAIL abort_drop: got %b required 00", {m1Ready, memRE});
            errors++;
        end
        tick();
        checks++;
        if ({grant, m1Ready, timeoutErr} !== 4'b0000) begin
            $display("FAIL abort_release: got %b required 0000", {grant, m1Ready, timeoutErr});
            errors++;
        end
        tick();
        checks++;
        if ({grant, m1Ready} !== 3'b000) begin
            $display("FAIL abort_idle: got %b required 000", {grant, m1Ready});
            errors++;
        end
    endtask

    task automatic test_reset_mid_busy;
        m0RE = 1'b1; m1RE = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b10) begin
            $display("FAIL rr_after_m0: got %b required 10", grant);
            errors++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({memRE, memWE, grant} !== 4'b0000) begin
            $display("FAIL async_reset: got %b required 0000", {memRE, memWE, grant});
            errors++;
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 2'b01) begin
            $display("FAIL reset_first_win: got %b required 01", grant);
            errors++;
        end
        tick();
        memReady = 1'b1;
        memRead  = 16'h1111;
        #1;
        checks++;
        if ({m0Ready, m1Ready} !== 2'b10 || m0Read !== 16'h1111) begin
            $display("FAIL reset_complete: got rdy %b read %h required 10 1111", {m0Ready, m1Ready}, m0Read);
            errors++;
        end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_re_we();
        test_timeout();
        test_abort();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
